// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (edge pulse registers).
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } ch_state_t;

  // Counter must be able to represent 0..clks inclusive.
  function automatic int cnt_width(input int clks);
    return (clks < 1) ? 1 : $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchronizer, stability counter, two-state FSM, edge pulses.
// Edge pulse registers exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CLKS = 10_000,
  parameter int SYNC_STAGES   = 2,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic debounce_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = cnt_width(DEBOUNCE_CLKS);
  // The toggle happens on the edge where the count would reach DEBOUNCE_CLKS,
  // so the register itself never holds more than DEBOUNCE_CLKS-1.
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CLKS - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync;
  ch_state_t              state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   out_reg, out_next;
  logic                   toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STABLE;
      cnt_reg   <= '0;
      out_reg   <= RESET_VALUE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    toggle     = 1'b0;
    case (state_reg)
      STABLE: begin
        if (sync != out_reg) begin
          state_next = PENDING;
          cnt_next   = CW'(1);
        end
      end
      PENDING: begin
        if (sync == out_reg) begin
          // Runt: discard progress entirely.
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == LAST_CNT) begin
          toggle     = 1'b1;
          state_next = STABLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    endcase
    out_next = out_reg ^ toggle;
  end

  assign debounce_out = out_reg;
  assign busy         = (state_reg == PENDING);

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_reg, fall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= toggle & ~out_reg;
      fall_reg <= toggle & out_reg;
    end
  end

  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// NUM_CH independent debounce channels sharing one clock and reset.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN (rise/fall pulses).
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DEBOUNCE_CLKS = 10_000,
  parameter int SYNC_STAGES   = 2,
  parameter bit RESET_VALUE   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] debounce_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] busy
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      debounce_ch #(
        .DEBOUNCE_CLKS(DEBOUNCE_CLKS),
        .SYNC_STAGES  (SYNC_STAGES),
        .RESET_VALUE  (RESET_VALUE)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .async_in    (async_in[gi]),
        .debounce_out(debounce_out[gi]),
        .rise_pulse  (rise_pulse[gi]),
        .fall_pulse  (fall_pulse[gi]),
        .busy        (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (4 channels, 100-cycle debounce).
module tb_debounce_multi;

  localparam int NUM_CH = 4;
  localparam int DCLKS  = 100;
  localparam int SYNC   = 2;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam logic PULSE_EN = 1'b1;
`else
  localparam logic PULSE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] debounce_out, rise_pulse, fall_pulse, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CLKS(DCLKS), .SYNC_STAGES(SYNC), .RESET_VALUE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .debounce_out(debounce_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [NUM_CH-1:0] pulse1;
  logic              bad;

  initial begin
    pulse1   = {{(NUM_CH-1){1'b0}}, PULSE_EN};
    rst      = 1'b1;
    async_in = '0;
    step(3);
    chk("reset_out",   debounce_out, 4'h0);
    chk("reset_busy",  busy,         4'h0);
    chk("reset_rise",  rise_pulse,   4'h0);
    chk("reset_fall",  fall_pulse,   4'h0);
    rst = 1'b0;
    step(2);

    // Clean rising step on ch0: new value seen 102 edges after driving.
    async_in = 4'b0001;
    step(101);
    chk("rise_not_yet", debounce_out, 4'h0);
    chk("rise_busy",    busy,         4'h1);
    step(1);
    chk("rise_out",     debounce_out, 4'h1);
    chk("rise_pulse",   rise_pulse,   32'(pulse1));
    chk("rise_busy_off", busy,        4'h0);
    step(1);
    chk("rise_pulse_end", rise_pulse, 4'h0);
    $display("clean rise ch0 done: out=%b", debounce_out);

    // Clean falling step on ch0.
    async_in = 4'b0000;
    step(101);
    chk("fall_not_yet", debounce_out, 4'h1);
    step(1);
    chk("fall_out",     debounce_out, 4'h0);
    chk("fall_pulse",   fall_pulse,   32'(pulse1));
    chk("fall_no_rise", rise_pulse,   4'h0);
    step(1);
    chk("fall_pulse_end", fall_pulse, 4'h0);
    $display("clean fall ch0 done: out=%b", debounce_out);

    // Runt on ch1: high for 50 cycles.
    async_in = 4'b0010;
    step(5);
    chk("runt_busy", busy, 4'h2);
    step(45);
    async_in = 4'b0000;
    step(10);
    chk("runt_busy_off", busy, 4'h0);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (debounce_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) bad = 1'b1;
    end
    chk("runt_stable", 32'(bad), 32'd0);
    $display("runt ch1 done: out=%b", debounce_out);

    // Runt train on ch2: 1 cycle on, 1 cycle off.
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      async_in = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      step(1);
      if (debounce_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) bad = 1'b1;
    end
    async_in = 4'b0000;
    step(5);
    chk("train_stable", 32'(bad), 32'd0);
    chk("train_busy",   busy,     4'h0);
    $display("runt train ch2 done: out=%b", debounce_out);

    // Concurrent: ch0+ch3 together, ch1 forty cycles later.
    async_in = 4'b1001;
    step(40);
    async_in = 4'b1011;
    step(61);
    chk("conc_not_yet", debounce_out, 4'h0);
    step(1);
    chk("conc_03",       debounce_out, 4'h9);
    chk("conc_03_pulse", rise_pulse,   32'(PULSE_EN ? 4'h9 : 4'h0));
    step(39);
    chk("conc_1_not_yet", debounce_out, 4'h9);
    step(1);
    chk("conc_1",       debounce_out, 4'hB);
    chk("conc_1_pulse", rise_pulse,   32'(PULSE_EN ? 4'h2 : 4'h0));
    $display("concurrent done: out=%b", debounce_out);

    // Reset mid-pending on ch0 (other inputs low so only ch0 debounces).
    rst = 1'b1;
    async_in = 4'b0000;
    step(2);
    rst = 1'b0;
    async_in = 4'b0001;
    step(62);
    chk("pend_busy", busy, 4'h1);
    rst = 1'b1;
    step(3);
    chk("pend_rst_out",  debounce_out, 4'h0);
    chk("pend_rst_busy", busy,         4'h0);
    chk("pend_rst_rise", rise_pulse,   4'h0);
    rst = 1'b0;
    step(101);
    chk("pend_not_yet", debounce_out, 4'h0);
    step(1);
    chk("pend_out",   debounce_out, 4'h1);
    chk("pend_pulse", rise_pulse,   32'(pulse1));
    $display("reset mid-pending done: out=%b", debounce_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
